// File: rtl/ej32_trace_buf.sv
// On-chip trace capture for the eJ32 core: records {code,phase,rp,p} per sample
// into a circular buffer (wrap / stop / trigger+post / call-return modes), drained FWFT.
module ej32_trace_buf #(
    parameter int          AW      = 16,
    parameter int          DEPTH   = 16,
    parameter int          POST    = 4,
    parameter logic [7:0]  OP_CALL = 8'hb6,
    parameter logic [7:0]  OP_RET  = 8'hb1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en_i,
    input  logic [1:0]                 mode_i,
    input  logic [7:0]                 trig_code_i,
    input  logic                       smp_vld_i,
    input  logic [AW-1:0]              smp_p_i,
    input  logic [4:0]                 smp_rp_i,
    input  logic [7:0]                 smp_code_i,
    input  logic [2:0]                 smp_phase_i,
    input  logic                       rd_rdy_i,
    output logic                       rd_vld_o,
    output logic [16+AW-1:0]           rd_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [1:0]                 state_o,
    output logic                       ovf_o
);
    // state | meaning
    // IDLE  | not capturing; contents retained and readable
    // ARMED | trigger mode: pre-trigger history recorded circularly
    // CAPT  | capturing per latched mode
    // DONE  | capture finished; waits for en low
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = 16 + AW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_CAPT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   post_cnt_q, post_cnt_d;
    logic            ovf_q, ovf_d;
    logic [DW-1:0]   mem_q [DEPTH];

    logic            full, call_evt, ret_evt, rec, pop;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        post_cnt_d = post_cnt_q;
        ovf_d      = ovf_q;

        full     = (count_q == CW'(DEPTH));
        call_evt = (smp_code_i == OP_CALL) && (smp_phase_i == 3'd2);
        ret_evt  = (smp_code_i == OP_RET)  && (smp_phase_i == 3'd0);
        rec      = en_i && smp_vld_i
                   && ((state_q == ST_ARMED) || (state_q == ST_CAPT))
                   && ((mode_q != 2'd3) || call_evt || ret_evt);
        pop      = (count_q != '0) && rd_rdy_i;

        if (rec) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        // A push into a full buffer with no concurrent pop evicts the oldest entry.
        if (rec && !pop) begin
            if (full) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                ovf_d    = 1'b1;
            end else begin
                count_d  = count_q + 1'b1;
            end
        end else if (pop && !rec) begin
            count_d = count_q - 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    count_d    = '0;
                    ovf_d      = 1'b0;
                    post_cnt_d = '0;
                    mode_d     = mode_i;
                    state_d    = (mode_i == 2'd2) ? ST_ARMED : ST_CAPT;
                end
            end
            ST_ARMED: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else if (rec && (smp_code_i == trig_code_i)) begin
                    post_cnt_d = CW'(POST);
                    state_d    = ST_CAPT;
                end
            end
            ST_CAPT: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else if ((mode_q == 2'd1) && (count_d == CW'(DEPTH))) begin
                    state_d = ST_DONE;
                end else if ((mode_q == 2'd2) && rec) begin
                    post_cnt_d = post_cnt_q - 1'b1;
                    if (post_cnt_q == CW'(1)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!en_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= 2'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            post_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            post_cnt_q <= post_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage needs no reset: validity is tracked entirely by count_q.
    always_ff @(posedge clk) begin
        if (rec) mem_q[wr_ptr_q] <= {smp_code_i, smp_phase_i, smp_rp_i, smp_p_i};
    end

    assign rd_vld_o  = (count_q != '0);
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign state_o   = state_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_ej32_trace_buf.sv
// Self-checking bench for ej32_trace_buf: directed capture-mode scenarios plus a
// randomized run against a queue-based reference model.
module tb_ej32_trace_buf;
    localparam int AW = 16;
    localparam int DEPTH = 16;
    localparam int POST = 4;

    typedef logic [31:0] ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  trig_code = 8'h10;
    logic        smp_vld = 1'b0;
    logic [15:0] smp_p = '0;
    logic [4:0]  smp_rp = '0;
    logic [7:0]  smp_code = '0;
    logic [2:0]  smp_phase = '0;
    logic        rd_rdy = 1'b0;
    logic        rd_vld;
    logic [31:0] rd_data;
    logic [4:0]  count;
    logic [1:0]  state;
    logic        ovf;

    int total = 0;
    int bad = 0;
    ent_t got[$];

    ej32_trace_buf #(.AW(AW), .DEPTH(DEPTH), .POST(POST)) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en), .mode_i(mode), .trig_code_i(trig_code),
        .smp_vld_i(smp_vld), .smp_p_i(smp_p), .smp_rp_i(smp_rp), .smp_code_i(smp_code),
        .smp_phase_i(smp_phase), .rd_rdy_i(rd_rdy), .rd_vld_o(rd_vld), .rd_data_o(rd_data),
        .count_o(count), .state_o(state), .ovf_o(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [1:0] m);
        smp_vld = 1'b0;
        rd_rdy = 1'b0;
        en = 1'b0;
        tick();
        en = 1'b1;
        mode = m;
        tick();
    endtask

    task automatic sample(input logic [15:0] p, input logic [7:0] code,
                          input logic [2:0] ph, input logic [4:0] rp);
        smp_vld = 1'b1;
        smp_p = p;
        smp_code = code;
        smp_phase = ph;
        smp_rp = rp;
        tick();
        smp_vld = 1'b0;
    endtask

    task automatic drain();
        got.delete();
        rd_rdy = 1'b1;
        for (int i = 0; i < 2 * DEPTH && rd_vld; i++) begin
            got.push_back(rd_data);
            tick();
        end
        rd_rdy = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (rd_vld !== 1'b0) begin bad++; $display("FAIL reset_rd_vld got=%b exp=0", rd_vld); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    endtask

    task automatic test_wrap();
        arm(2'd0);
        total++; if (state !== 2'd2) begin bad++; $display("FAIL wrap_arm_state got=%0d exp=2", state); end
        for (int i = 0; i < 20; i++) sample(16'(i), 8'h20, 3'(i % 8), 5'(i));
        total++; if (count !== 5'd16) begin bad++; $display("FAIL wrap_count got=%0d exp=16", count); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL wrap_ovf got=%b exp=1", ovf); end
        drain();
        total++; if (got.size() != 16) begin bad++; $display("FAIL wrap_drain_len got=%0d exp=16", got.size()); end
        for (int k = 0; k < got.size(); k++) begin
            total++;
            if (got[k][15:0] !== 16'(k + 4)) begin bad++; $display("FAIL wrap_p[%0d] got=%0d exp=%0d", k, got[k][15:0], k + 4); end
        end
    endtask

    task automatic test_stop();
        arm(2'd1);
        for (int i = 0; i < 20; i++) begin
            sample(16'(i), 8'h21, 3'd1, 5'd3);
            if (i == 15) begin
                total++; if (state !== 2'd3) begin bad++; $display("FAIL stop_done_at16 got=%0d exp=3", state); end
            end
        end
        total++; if (count !== 5'd16) begin bad++; $display("FAIL stop_count got=%0d exp=16", count); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL stop_ovf got=%b exp=0", ovf); end
        drain();
        total++; if (got.size() != 16) begin bad++; $display("FAIL stop_drain_len got=%0d exp=16", got.size()); end
        for (int k = 0; k < got.size(); k++) begin
            total++;
            if (got[k][15:0] !== 16'(k)) begin bad++; $display("FAIL stop_p[%0d] got=%0d exp=%0d", k, got[k][15:0], k); end
        end
    endtask

    task automatic test_trig();
        trig_code = 8'h10;
        arm(2'd2);
        total++; if (state !== 2'd1) begin bad++; $display("FAIL trig_armed got=%0d exp=1", state); end
        for (int i = 0; i < 6; i++) sample(16'(i), 8'h20, 3'd0, 5'd0);
        sample(16'd6, 8'h10, 3'd0, 5'd0);
        total++; if (state !== 2'd2) begin bad++; $display("FAIL trig_capt got=%0d exp=2", state); end
        for (int i = 7; i < 17; i++) sample(16'(i), 8'h20, 3'd0, 5'd0);
        total++; if (state !== 2'd3) begin bad++; $display("FAIL trig_done got=%0d exp=3", state); end
        total++; if (count !== 5'd11) begin bad++; $display("FAIL trig_count got=%0d exp=11", count); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL trig_ovf got=%b exp=0", ovf); end
        drain();
        total++; if (got.size() != 11) begin bad++; $display("FAIL trig_drain_len got=%0d exp=11", got.size()); end
        for (int k = 0; k < got.size(); k++) begin
            total++;
            if (got[k][15:0] !== 16'(k)) begin bad++; $display("FAIL trig_p[%0d] got=%0d exp=%0d", k, got[k][15:0], k); end
        end
    endtask

    task automatic test_calls();
        ent_t exp_q[$];
        arm(2'd3);
        sample(16'd100, 8'hb6, 3'd2, 5'd1);
        sample(16'd101, 8'hb6, 3'd1, 5'd2);
        sample(16'd102, 8'h20, 3'd2, 5'd4);
        sample(16'd103, 8'hb1, 3'd0, 5'd1);
        sample(16'd104, 8'hb1, 3'd3, 5'd5);
        sample(16'd105, 8'h20, 3'd0, 5'd6);
        exp_q = '{{8'hb6, 3'd2, 5'd1, 16'd100}, {8'hb1, 3'd0, 5'd1, 16'd103}};
        total++; if (count !== 5'd2) begin bad++; $display("FAIL calls_count got=%0d exp=2", count); end
        drain();
        total++; if (got.size() != 2) begin bad++; $display("FAIL calls_len got=%0d exp=2", got.size()); end
        for (int k = 0; k < got.size() && k < 2; k++) begin
            total++;
            if (got[k] !== exp_q[k]) begin bad++; $display("FAIL calls_entry[%0d] got=%h exp=%h", k, got[k], exp_q[k]); end
        end
    endtask

    task automatic test_push_pop_full();
        ent_t popped;
        arm(2'd0);
        for (int i = 0; i < 16; i++) sample(16'(i), 8'h22, 3'd0, 5'd0);
        total++; if (count !== 5'd16) begin bad++; $display("FAIL pp_full_count got=%0d exp=16", count); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL pp_full_ovf got=%b exp=0", ovf); end
        popped = rd_data;
        rd_rdy = 1'b1;
        sample(16'd16, 8'h22, 3'd0, 5'd0);
        rd_rdy = 1'b0;
        total++; if (popped[15:0] !== 16'd0) begin bad++; $display("FAIL pp_popped got=%0d exp=0", popped[15:0]); end
        total++; if (count !== 5'd16) begin bad++; $display("FAIL pp_count got=%0d exp=16", count); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL pp_ovf got=%b exp=0", ovf); end
        drain();
        total++; if (got.size() != 16) begin bad++; $display("FAIL pp_drain_len got=%0d exp=16", got.size()); end
        for (int k = 0; k < got.size(); k++) begin
            total++;
            if (got[k][15:0] !== 16'(k + 1)) begin bad++; $display("FAIL pp_p[%0d] got=%0d exp=%0d", k, got[k][15:0], k + 1); end
        end
    endtask

    task automatic test_async_reset();
        arm(2'd0);
        for (int i = 0; i < 7; i++) sample(16'(i), 8'h23, 3'd0, 5'd0);
        total++; if (count !== 5'd7) begin bad++; $display("FAIL arst_pre_count got=%0d exp=7", count); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (state !== 2'd0) begin bad++; $display("FAIL arst_state got=%0d exp=0", state); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL arst_count got=%0d exp=0", count); end
        total++; if (rd_vld !== 1'b0) begin bad++; $display("FAIL arst_rd_vld got=%b exp=0", rd_vld); end
        tick();
        rst_n = 1'b1;
        en = 1'b0;
        tick();
    endtask

    task automatic test_random();
        ent_t mq[$];
        int mst, mmode, mpost;
        bit movf, pop, rec, evt;
        logic [7:0] codes [4];
        ent_t e;
        codes = '{8'hb6, 8'hb1, 8'h10, 8'h20};
        en = 1'b0; smp_vld = 1'b0; rd_rdy = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        mst = 0; mmode = 0; mpost = 0; movf = 1'b0;
        trig_code = 8'h10;
        for (int c = 0; c < 3000; c++) begin
            total++; if (count !== 5'(mq.size())) begin bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, mq.size()); end
            total++; if (state !== 2'(mst)) begin bad++; $display("FAIL rnd_state c=%0d got=%0d exp=%0d", c, state, mst); end
            total++; if (ovf !== movf) begin bad++; $display("FAIL rnd_ovf c=%0d got=%b exp=%b", c, ovf, movf); end
            total++; if (rd_vld !== (mq.size() != 0)) begin bad++; $display("FAIL rnd_rd_vld c=%0d got=%b exp=%b", c, rd_vld, mq.size() != 0); end
            if (mq.size() != 0) begin
                total++; if (rd_data !== mq[0]) begin bad++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, rd_data, mq[0]); end
            end

            en = ($urandom_range(0, 39) != 0);
            mode = 2'($urandom_range(0, 3));
            smp_vld = ($urandom_range(0, 9) < 7);
            smp_code = codes[$urandom_range(0, 3)];
            smp_phase = 3'($urandom_range(0, 3));
            smp_rp = 5'($urandom);
            smp_p = 16'($urandom);
            rd_rdy = ($urandom_range(0, 9) < 3);

            e = {smp_code, smp_phase, smp_rp, smp_p};
            evt = ((smp_code == 8'hb6) && (smp_phase == 3'd2)) || ((smp_code == 8'hb1) && (smp_phase == 3'd0));
            pop = (mq.size() != 0) && rd_rdy;
            if (mst == 0) begin
                if (en) begin
                    mq.delete(); movf = 1'b0; mmode = int'(mode);
                    mst = (mode == 2'd2) ? 1 : 2;
                end else if (pop) begin
                    void'(mq.pop_front());
                end
            end else begin
                rec = en && smp_vld && (mst == 1 || mst == 2) && (mmode != 3 || evt);
                if (pop) void'(mq.pop_front());
                if (rec) begin
                    mq.push_back(e);
                    if (mq.size() > DEPTH) begin void'(mq.pop_front()); movf = 1'b1; end
                end
                if (!en) mst = 0;
                else if (mst == 1) begin
                    if (rec && smp_code == trig_code) begin mpost = POST; mst = 2; end
                end else if (mst == 2) begin
                    if (mmode == 1 && mq.size() == DEPTH) mst = 3;
                    else if (mmode == 2 && rec) begin mpost--; if (mpost == 0) mst = 3; end
                end
            end
            tick();
        end
        en = 1'b0; smp_vld = 1'b0; rd_rdy = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_wrap();
        test_stop();
        test_trig();
        test_calls();
        test_push_pop_full();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
